// File: rtl/frame_writeback_rgb888.sv
// Frame-buffer write-back: buffers the raster pixel stream in a small address-tagged
// FIFO and writes it to BRAM at BASE_ADDR + pixel index whenever the write port is granted.
module frame_writeback_rgb888 #(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 17,
    parameter int WIDTH      = 480,
    parameter int HEIGHT     = 272,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iPixel,
    output logic              oCs,
    output logic              oWe,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oWrData,
    input  logic              iGrant,
    output logic              oBusy,
    output logic              oDone,
    output logic              oOverflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

    logic              not_empty, full, in_run, push, pop, drop;
    logic [ADDR_W-1:0] wr_addr;

    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == FULL_CNT);
        in_run    = (state_q == S_RUN);
        pop       = not_empty && iGrant;
        // a full FIFO still accepts a pixel when the head leaves on the same edge
        push      = iValid && in_run && (!full || pop);
        drop      = iValid && in_run && full && !pop;
        wr_addr   = BASE + idx_q;

        state_d  = state_q;
        idx_d    = idx_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop) ovf_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d  = S_RUN;
                    idx_d    = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (iValid) begin
                    idx_d = idx_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= wr_addr;
            data_mem_q[wr_ptr_q] <= iPixel;
        end
    end

    // head is masked while empty so stale or uninitialised entries never reach the port
    assign oCs       = not_empty;
    assign oWe       = not_empty;
    assign oAddr     = not_empty ? addr_mem_q[rd_ptr_q] : '0;
    assign oWrData   = not_empty ? data_mem_q[rd_ptr_q] : '0;
    assign oBusy     = (state_q != S_IDLE);
    assign oDone     = (state_q == S_DONE);
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_frame_writeback_rgb888.sv
// Randomised self-checking bench for frame_writeback_rgb888 on a 4x3 frame at base 16,
// compared against a queue-level model of pushes and drops.
module tb_frame_writeback_rgb888;

    localparam int DW = 24;
    localparam int AW = 17;
    localparam int W = 4;
    localparam int H = 3;
    localparam int BASE = 16;
    localparam int D = 4;
    localparam int TOTAL = W * H;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iStart = 1'b0;
    logic          iValid = 1'b0;
    logic          iGrant = 1'b0;
    logic [DW-1:0] iPixel = '0;
    logic          oCs, oWe, oBusy, oDone, oOverflow;
    logic [AW-1:0] oAddr;
    logic [DW-1:0] oWrData;

    frame_writeback_rgb888 #(
        .DATA_W(DW), .ADDR_W(AW), .WIDTH(W), .HEIGHT(H),
        .BASE_ADDR(BASE), .FIFO_DEPTH(D)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iValid(iValid), .iPixel(iPixel),
        .oCs(oCs), .oWe(oWe), .oAddr(oAddr), .oWrData(oWrData), .iGrant(iGrant),
        .oBusy(oBusy), .oDone(oDone), .oOverflow(oOverflow)
    );

    always #5 iClk = ~iClk;

    int unsigned cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    int            done_cnt = 0;
    int unsigned   done_cyc = 0;
    int unsigned   last_edge = 0;
    int unsigned   idle_cyc = 0;

    // writes captured half a cycle before the edge that completes them
    always @(negedge iClk) begin
        n_cmp++;
        if (oWe !== oCs) begin
            n_bad++;
            $display("FAIL we_eq_cs: oWe=%b required %b", oWe, oCs);
        end
        if (iRst === 1'b1 && oCs === 1'b1 && iGrant === 1'b1) begin
            wa.push_back(oAddr);
            wd.push_back(oWrData);
        end
        if (oDone === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    bit            vv[$];
    bit            gg[$];
    bit            ss[$];
    logic [DW-1:0] pdat[TOTAL];

    task automatic clear_pattern();
        vv.delete(); gg.delete(); ss.delete();
    endtask

    task automatic run_frame(input string name);
        logic [AW-1:0] ea[$];
        logic [DW-1:0] ed[$];
        int  size = 0;
        int  idx = 0;
        int  sent = 0;
        int  t = 0;
        bit  eovf = 0;
        bit  pop;
        int  n = vv.size();

        for (int k = 0; k < n; k++) begin
            pop = (size > 0) && gg[k];
            if (vv[k] && idx < TOTAL) begin
                if (size < D || pop) begin
                    ea.push_back(AW'(BASE + idx));
                    ed.push_back(pdat[idx]);
                    size++;
                end else begin
                    eovf = 1;
                end
                idx++;
            end
            if (pop) size--;
        end

        @(posedge iClk); #1;
        wa.delete(); wd.delete(); done_cnt = 0;
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        for (int k = 0; k < n; k++) begin
            iValid = vv[k];
            iGrant = gg[k];
            iStart = ss[k];
            iPixel = (sent < TOTAL) ? pdat[sent] : '0;
            @(posedge iClk); #1;
            if (vv[k] && sent < TOTAL) begin
                sent++;
                if (sent == TOTAL) last_edge = cyc;
            end
        end
        iValid = 1'b0; iStart = 1'b0; iGrant = 1'b1;

        @(negedge iClk);
        while (oBusy === 1'b1 && t < 200) begin
            @(negedge iClk);
            t++;
        end
        idle_cyc = cyc;
        n_cmp++;
        if (oBusy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_timeout: oBusy=%b required 0", name, oBusy);
        end

        n_cmp++;
        if (wa.size() !== ea.size()) begin
            n_bad++;
            $display("FAIL %s_write_count: got %0d required %0d", name, wa.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            n_cmp++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                n_bad++;
                $display("FAIL %s_write%0d: got addr=%0d data=%h required addr=%0d data=%h",
                         name, i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
        n_cmp++;
        if (oOverflow !== eovf) begin
            n_bad++;
            $display("FAIL %s_overflow: got %b required %b", name, oOverflow, eovf);
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_bad++;
            $display("FAIL %s_done_count: got %0d required 1", name, done_cnt);
        end
    endtask

    task automatic test_reset();
        #2 iRst = 1'b0;
        @(negedge iClk);
        n_cmp++;
        if ({oCs, oWe, oAddr, oWrData, oBusy, oDone, oOverflow} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got cs=%b addr=%h data=%h busy=%b done=%b ovf=%b required all 0",
                     oCs, oAddr, oWrData, oBusy, oDone, oOverflow);
        end
        @(posedge iClk); #1 iRst = 1'b1;

        for (int i = 0; i < TOTAL; i++) pdat[i] = DW'($urandom);
        @(posedge iClk); #1 iStart = 1'b1;
        @(posedge iClk); #1 iStart = 1'b0;
        for (int k = 0; k < 6; k++) begin
            iValid = 1'b1; iGrant = 1'b0; iPixel = pdat[k];
            @(posedge iClk); #1;
            if (k == 0) begin
                @(negedge iClk);
                n_cmp++;
                if (oCs !== 1'b1 || oAddr !== AW'(BASE) || oWrData !== pdat[0]) begin
                    n_bad++;
                    $display("FAIL first_latency: got cs=%b addr=%0d data=%h required 1 %0d %h",
                             oCs, oAddr, oWrData, BASE, pdat[0]);
                end
            end
        end
        iValid = 1'b0;
        @(negedge iClk);
        n_cmp++;
        if (oOverflow !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_overflow: got %b required 1", oOverflow);
        end
        @(posedge iClk); #1 iRst = 1'b0;
        @(negedge iClk);
        n_cmp++;
        if ({oCs, oWe, oAddr, oWrData, oBusy, oDone, oOverflow} !== '0) begin
            n_bad++;
            $display("FAIL midframe_reset: got cs=%b addr=%h busy=%b done=%b ovf=%b required all 0",
                     oCs, oAddr, oBusy, oDone, oOverflow);
        end
        @(posedge iClk); #1 iRst = 1'b1;

        clear_pattern();
        for (int k = 0; k < TOTAL; k++) begin vv.push_back(1); gg.push_back(1); ss.push_back(0); end
        run_frame("after_reset");
        n_cmp++;
        if (wa.size() == 0 || wa[0] !== AW'(BASE)) begin
            n_bad++;
            $display("FAIL after_reset_first_addr: got %0d required %0d",
                     (wa.size() == 0) ? -1 : int'(wa[0]), BASE);
        end
    endtask

    task automatic test_small_frame();
        for (int i = 0; i < TOTAL; i++) pdat[i] = DW'(32'hA00000 + i);
        clear_pattern();
        for (int k = 0; k < TOTAL; k++) begin vv.push_back(1); gg.push_back(1); ss.push_back(0); end
        run_frame("small_frame");
        n_cmp++;
        if (done_cyc !== last_edge + 2) begin
            n_bad++;
            $display("FAIL done_timing: got cycle %0d required %0d", done_cyc, last_edge + 2);
        end
        n_cmp++;
        if (idle_cyc !== last_edge + 3) begin
            n_bad++;
            $display("FAIL idle_timing: got cycle %0d required %0d", idle_cyc, last_edge + 3);
        end
    endtask

    task automatic test_backpressure();
        int hits = 0;
        for (int i = 0; i < TOTAL; i++) pdat[i] = DW'($urandom);
        clear_pattern();
        for (int k = 0; k < TOTAL; k++) begin
            vv.push_back(1); gg.push_back(k >= 6); ss.push_back(0);
        end
        run_frame("backpressure");
        foreach (wa[i]) if (wa[i] == AW'(BASE + 4) || wa[i] == AW'(BASE + 5)) hits++;
        n_cmp++;
        if (hits !== 0 || oOverflow !== 1'b1 || wa.size() !== TOTAL - 2) begin
            n_bad++;
            $display("FAIL dropped_addrs: got hits=%0d ovf=%b writes=%0d required 0 1 %0d",
                     hits, oOverflow, wa.size(), TOTAL - 2);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < TOTAL; i++) pdat[i] = DW'($urandom);
        clear_pattern();
        for (int k = 0; k < TOTAL; k++) begin
            vv.push_back(1); gg.push_back(k >= 4); ss.push_back(0);
        end
        run_frame("full_push_pop");
        n_cmp++;
        if (oOverflow !== 1'b0 || wa.size() !== TOTAL) begin
            n_bad++;
            $display("FAIL full_no_drop: got ovf=%b writes=%0d required 0 %0d",
                     oOverflow, wa.size(), TOTAL);
        end
    endtask

    task automatic test_ignored_inputs();
        @(posedge iClk); #1;
        wa.delete(); wd.delete();
        iGrant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iValid = k[0]; iPixel = DW'($urandom);
            @(posedge iClk); #1;
        end
        iValid = 1'b0;
        @(negedge iClk);
        n_cmp++;
        if (wa.size() !== 0 || oBusy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_valid: got writes=%0d busy=%b required 0 0", wa.size(), oBusy);
        end
        for (int i = 0; i < TOTAL; i++) pdat[i] = DW'($urandom);
        clear_pattern();
        for (int k = 0; k < TOTAL; k++) begin
            vv.push_back(1); gg.push_back(1); ss.push_back(k == 5);
        end
        run_frame("start_in_run");
    endtask

    task automatic test_gapped_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < TOTAL; i++) pdat[i] = DW'($urandom);
            clear_pattern();
            for (int k = 0; k < 2 * TOTAL; k++) begin
                vv.push_back(k % 2 == 0); gg.push_back($urandom_range(1, 0) == 1); ss.push_back(0);
            end
            run_frame("gapped");
        end
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_backpressure();
        test_full_push_pop();
        test_ignored_inputs();
        test_gapped_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
